ds_burst_router: RTL and testbench



---
 rtl/ds_burst_router_if.sv | 36 +++
 rtl/ds_burst_router.sv | 130 +++++++++++++
 tb/tb_ds_burst_router.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ds_burst_router_if.sv
// Packet/beat bus between the frame parser, the burst router and the per-channel FIFOs.
// Latency: n/a (signal bundle only).
// Backpressure: none on beats; per-channel prog_full is consulted only at packet start.
// Signals:
//   pkt_start/des_id/pkt_len     packet header, qualified by the one-cycle pkt_start pulse
//   ds_burst_valid/ds_burst_data beat stream from the parser
//   ds_burst_wr_en/ds_burst_dout one-hot FIFO write enable and per-channel data slices
//   ds_burst_prog_full           per-channel FIFO nearly-full flags
//   pkt_done                     last beat of a forwarded packet, aligned with its wr_en
interface ds_burst_router_if #(
    parameter int DS_CHANNEL = 8,
    parameter int DATA_W     = 128,
    parameter int ID_W       = 8
);
    logic                         pkt_start;
    logic [ID_W-1:0]              des_id;
    logic [15:0]                  pkt_len;
    logic                         ds_burst_valid;
    logic [DATA_W-1:0]            ds_burst_data;
    logic [DS_CHANNEL-1:0]        ds_burst_wr_en;
    logic [DS_CHANNEL*DATA_W-1:0] ds_burst_dout;
    logic [DS_CHANNEL-1:0]        ds_burst_prog_full;
    logic                         pkt_done;

    // Parser/FIFO side: drives the packet stream and FIFO status, observes the router outputs.
    modport master (
        output pkt_start, des_id, pkt_len, ds_burst_valid, ds_burst_data, ds_burst_prog_full,
        input  ds_burst_wr_en, ds_burst_dout, pkt_done
    );

    // Router side.
    modport slave (
        input  pkt_start, des_id, pkt_len, ds_burst_valid, ds_burst_data, ds_burst_prog_full,
        output ds_burst_wr_en, ds_burst_dout, pkt_done
    );
endinterface

// File: rtl/ds_burst_router.sv
// Routes whole packets by destination ID to one of DS_CHANNEL FIFOs; unknown/full targets are dropped whole.
// Latency: 1 cycle registered from beat valid to wr_en/dout/pkt_done.
// Backpressure: none mid-packet; prog_full is sampled at packet start and turns the packet into a drop.
// Ports:
//   sys_clk_i, rst_n_i       clock, asynchronous active-low reset
//   bus_if (slave)           packet header, beat stream, FIFO write side and prog_full
//   drop_pkt_cnt_o           saturating count of dropped packets
//   err_cnt_o                saturating count of protocol errors (stray beat, zero length, early start)
module ds_burst_router #(
    parameter int                         DS_CHANNEL = 8,
    parameter int                         DATA_W     = 128,
    parameter int                         ID_W       = 8,
    parameter logic [DS_CHANNEL*ID_W-1:0] ID_TABLE   = 64'h10_11_1C_1B_1A_19_18_17,
    parameter int                         CNT_W      = 16
) (
    input  logic             sys_clk_i,
    input  logic             rst_n_i,
    ds_burst_router_if.slave bus_if,
    output logic [CNT_W-1:0] drop_pkt_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int CH_W = (DS_CHANNEL > 1) ? $clog2(DS_CHANNEL) : 1;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t                       state_q;
    logic [CH_W-1:0]              ch_q;
    logic [15:0]                  rem_q;
    logic [DS_CHANNEL-1:0]        wr_en_q;
    logic [DS_CHANNEL*DATA_W-1:0] dout_q;
    logic                         done_q;
    logic [CNT_W-1:0]             drop_cnt_q;
    logic [CNT_W-1:0]             err_cnt_q;

    // ID lookup: scanning from the top down lets the lowest matching index win.
    logic            id_hit;
    logic [CH_W-1:0] id_ch;

    always_comb begin
        id_hit = 1'b0;
        id_ch  = '0;
        for (int k = DS_CHANNEL - 1; k >= 0; k--) begin
            if (bus_if.des_id == ID_TABLE[k*ID_W +: ID_W]) begin
                id_hit = 1'b1;
                id_ch  = CH_W'(k);
            end
        end
    end

    // Packet-start resolution. A start overrides whatever packet is in flight, so the beat
    // arriving in the same cycle is processed under the "effective" state computed here.
    state_t          eff_state;
    logic [CH_W-1:0] eff_ch;
    logic [15:0]     eff_rem;
    logic [1:0]      err_inc;
    logic            drop_inc;

    always_comb begin
        eff_state = state_q;
        eff_ch    = ch_q;
        eff_rem   = rem_q;
        err_inc   = 2'd0;
        drop_inc  = 1'b0;
        if (bus_if.pkt_start) begin
            if (state_q != IDLE) begin
                err_inc = err_inc + 2'd1;           // early start abandons the current packet
            end
            eff_rem = bus_if.pkt_len;
            if (bus_if.pkt_len == 16'd0) begin
                err_inc   = err_inc + 2'd1;
                eff_state = IDLE;
            end else if (!id_hit || bus_if.ds_burst_prog_full[id_ch]) begin
                drop_inc  = 1'b1;
                eff_state = DROP;
            end else begin
                eff_state = FWD;
                eff_ch    = id_ch;
            end
        end else if (bus_if.ds_burst_valid && state_q == IDLE) begin
            err_inc = 2'd1;                         // stray beat outside any packet
        end
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            rem_q      <= '0;
            wr_en_q    <= '0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            wr_en_q    <= '0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            ch_q       <= eff_ch;
            err_cnt_q  <= sat_add(err_cnt_q, err_inc);
            drop_cnt_q <= sat_add(drop_cnt_q, {1'b0, drop_inc});
            if (bus_if.ds_burst_valid && eff_state != IDLE) begin
                // DROP consumes beats exactly like FWD but never writes a FIFO.
                if (eff_state == FWD) begin
                    wr_en_q[eff_ch]                     <= 1'b1;
                    dout_q[int'(eff_ch)*DATA_W +: DATA_W] <= bus_if.ds_burst_data;
                    done_q                              <= (eff_rem == 16'd1);
                end
                state_q <= (eff_rem == 16'd1) ? IDLE : eff_state;
                rem_q   <= eff_rem - 16'd1;
            end else begin
                state_q <= eff_state;
                rem_q   <= eff_rem;
            end
        end
    end

    assign bus_if.ds_burst_wr_en = wr_en_q;
    assign bus_if.ds_burst_dout  = dout_q;
    assign bus_if.pkt_done       = done_q;
    assign drop_pkt_cnt_o        = drop_cnt_q;
    assign err_cnt_o             = err_cnt_q;

endmodule

// File: tb/tb_ds_burst_router.sv
// Testbench for ds_burst_router: default build driven by directed + random packets against a
// packet-level reference model; a small build (4 ch, 64b, 2b counters) for priority, saturation
// and asynchronous reset.
module tb_ds_burst_router;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n, rst2_n;

    ds_burst_router_if #(.DS_CHANNEL(8), .DATA_W(128), .ID_W(8)) bus1 ();
    ds_burst_router_if #(.DS_CHANNEL(4), .DATA_W(64),  .ID_W(8)) bus2 ();

    logic [15:0] drop1, err1;
    logic [1:0]  drop2, err2;

    ds_burst_router #(
        .DS_CHANNEL(8), .DATA_W(128), .ID_W(8),
        .ID_TABLE(64'h10_11_1C_1B_1A_19_18_17), .CNT_W(16)
    ) dut1 (
        .sys_clk_i(clk), .rst_n_i(rst1_n), .bus_if(bus1),
        .drop_pkt_cnt_o(drop1), .err_cnt_o(err1)
    );

    ds_burst_router #(
        .DS_CHANNEL(4), .DATA_W(64), .ID_W(8),
        .ID_TABLE(32'h5A_C2_5A_C0), .CNT_W(2)
    ) dut2 (
        .sys_clk_i(clk), .rst_n_i(rst2_n), .bus_if(bus2),
        .drop_pkt_cnt_o(drop2), .err_cnt_o(err2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model for the default build ----------------
    logic [63:0] tbl1 = 64'h10_11_1C_1B_1A_19_18_17;

    typedef enum int {M_NONE, M_FWD, M_DROP} pkt_mode_t;
    pkt_mode_t   m_mode = M_NONE;   // what the packet in flight is doing
    int          m_ch   = 0;
    int          m_left = 0;        // beats still owed by the packet in flight
    int          m_drop = 0;
    int          m_err  = 0;
    logic [7:0]    e_wr;
    logic [1023:0] e_dout;
    logic          e_done;

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model1(input bit st, input logic [7:0] id, input logic [15:0] len,
                          input bit v, input logic [127:0] d, input logic [7:0] pf);
        int ch;
        e_wr   = '0;
        e_dout = '0;
        e_done = 1'b0;
        if (st) begin
            if (m_mode != M_NONE) m_err = sat16(m_err + 1);
            m_mode = M_NONE;
            if (len == 0) begin
                m_err = sat16(m_err + 1);
            end else begin
                ch = -1;
                for (int k = 0; k < 8; k++)
                    if (ch < 0 && tbl1[k*8 +: 8] == id) ch = k;
                m_left = len;
                if (ch < 0 || pf[ch]) begin
                    m_drop = sat16(m_drop + 1);
                    m_mode = M_DROP;
                end else begin
                    m_mode = M_FWD;
                    m_ch   = ch;
                end
            end
        end
        if (v) begin
            if (m_mode == M_NONE) begin
                if (!st) m_err = sat16(m_err + 1);
            end else begin
                if (m_mode == M_FWD) begin
                    e_wr[m_ch]               = 1'b1;
                    e_dout[m_ch*128 +: 128]  = d;
                    e_done                   = (m_left == 1);
                end
                m_left--;
                if (m_left == 0) m_mode = M_NONE;
            end
        end
    endtask

    task automatic step1(input bit st, input logic [7:0] id, input logic [15:0] len,
                         input bit v, input logic [127:0] d, input logic [7:0] pf);
        bus1.pkt_start          = st;
        bus1.des_id             = id;
        bus1.pkt_len            = len;
        bus1.ds_burst_valid     = v;
        bus1.ds_burst_data      = d;
        bus1.ds_burst_prog_full = pf;
        model1(st, id, len, v, d, pf);
        @(posedge clk);
        #1;
        chk("wr_en",    bus1.ds_burst_wr_en, e_wr);
        chk("dout",     bus1.ds_burst_dout,  e_dout);
        chk("pkt_done", bus1.pkt_done,       e_done);
        chk("drop_cnt", drop1,               m_drop[15:0]);
        chk("err_cnt",  err1,                m_err[15:0]);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle2();
        bus2.pkt_start      = 1'b0;
        bus2.des_id         = 8'h00;
        bus2.pkt_len        = 16'd0;
        bus2.ds_burst_valid = 1'b0;
        bus2.ds_burst_data  = '0;
    endtask

    task automatic beat2(input bit st, input logic [7:0] id, input logic [15:0] len, input logic [63:0] d);
        bus2.pkt_start      = st;
        bus2.des_id         = id;
        bus2.pkt_len        = len;
        bus2.ds_burst_valid = 1'b1;
        bus2.ds_burst_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0]  d2;
        logic [255:0] exp_dout2;
        logic [7:0]   rid;
        logic [15:0]  rlen;

        // ---------------- reset ----------------
        rst1_n = 1'b0;
        rst2_n = 1'b0;
        bus1.pkt_start = 1'b0; bus1.des_id = '0; bus1.pkt_len = '0;
        bus1.ds_burst_valid = 1'b0; bus1.ds_burst_data = '0; bus1.ds_burst_prog_full = '0;
        bus2.ds_burst_prog_full = '0;
        idle2();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en",    bus1.ds_burst_wr_en, 0);
        chk("rst_dout",     bus1.ds_burst_dout,  0);
        chk("rst_pkt_done", bus1.pkt_done,       0);
        chk("rst_drop_cnt", drop1,               0);
        chk("rst_err_cnt",  err1,                0);
        @(negedge clk);
        rst1_n = 1'b1;
        rst2_n = 1'b1;

        // 1: des 0x19 len 4 -> channel 2
        step1(1, 8'h19, 4, 1, rnd128(), 8'h00);
        for (int i = 0; i < 3; i++) step1(0, 8'h00, 0, 1, rnd128(), 8'h00);
        step1(0, 8'h00, 0, 0, '0, 8'h00);

        // 2: unknown ID dropped, then des 0x10 -> channel 7
        step1(1, 8'h55, 3, 1, rnd128(), 8'h00);
        for (int i = 0; i < 2; i++) step1(0, 8'h00, 0, 1, rnd128(), 8'h00);
        step1(1, 8'h10, 2, 1, rnd128(), 8'h00);
        step1(0, 8'h00, 0, 1, rnd128(), 8'h00);
        step1(0, 8'h00, 0, 0, '0, 8'h00);

        // 3: prog_full only at start drops; prog_full only mid-packet does not
        step1(1, 8'h11, 5, 1, rnd128(), 8'h40);
        for (int i = 0; i < 4; i++) step1(0, 8'h00, 0, 1, rnd128(), 8'h00);
        step1(1, 8'h11, 5, 1, rnd128(), 8'h00);
        for (int i = 0; i < 4; i++) step1(0, 8'h00, 0, 1, rnd128(), 8'h40);
        step1(0, 8'h00, 0, 0, '0, 8'h00);

        // 4: single-beat packet back-to-back with a two-beat packet
        step1(1, 8'h17, 1, 1, rnd128(), 8'h00);
        step1(1, 8'h18, 2, 1, rnd128(), 8'h00);
        step1(0, 8'h00, 0, 1, rnd128(), 8'h00);
        step1(0, 8'h00, 0, 0, '0, 8'h00);

        // 5: stray beat, zero length, early start
        step1(0, 8'h00, 0, 1, rnd128(), 8'h00);
        step1(1, 8'h19, 0, 0, '0, 8'h00);
        step1(1, 8'h19, 8, 1, rnd128(), 8'h00);
        for (int i = 0; i < 2; i++) step1(0, 8'h00, 0, 1, rnd128(), 8'h00);
        step1(1, 8'h1A, 2, 1, rnd128(), 8'h00);
        step1(0, 8'h00, 0, 1, rnd128(), 8'h00);
        step1(0, 8'h00, 0, 0, '0, 8'h00);

        // random traffic: known/unknown IDs, gaps, prog_full, early starts, strays
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) rid = tbl1[$urandom_range(0, 7)*8 +: 8];
            else                          rid = 8'($urandom);
            rlen = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
            step1(($urandom_range(0, 6) == 0), rid, rlen, ($urandom_range(0, 4) != 0), rnd128(),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
        end
        step1(0, 8'h00, 0, 0, '0, 8'h00);

        // 6: small build -- duplicate ID picks entry 1
        d2 = {$urandom, $urandom};
        beat2(1, 8'h5A, 1, d2);
        exp_dout2 = '0;
        exp_dout2[64 +: 64] = d2;
        chk("dup_wr_en",    bus2.ds_burst_wr_en, 4'b0010);
        chk("dup_dout",     bus2.ds_burst_dout,  exp_dout2);
        chk("dup_pkt_done", bus2.pkt_done,       1);

        // drop counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            beat2(1, 8'h77, 1, {$urandom, $urandom});
            chk("sat_drop_cnt", drop2, (i + 1 > 3) ? 3 : i + 1);
            chk("sat_wr_en",    bus2.ds_burst_wr_en, 0);
        end
        chk("sat_err_cnt", err2, 0);

        // reset in the middle of a packet clears everything asynchronously
        d2 = {$urandom, $urandom};
        beat2(1, 8'hC2, 4, d2);
        exp_dout2 = '0;
        exp_dout2[128 +: 64] = d2;
        chk("pre_rst_wr_en", bus2.ds_burst_wr_en, 4'b0100);
        chk("pre_rst_dout",  bus2.ds_burst_dout,  exp_dout2);
        beat2(0, 8'h00, 0, {$urandom, $urandom});
        #2;
        rst2_n = 1'b0;
        #1;
        chk("arst_wr_en",    bus2.ds_burst_wr_en, 0);
        chk("arst_dout",     bus2.ds_burst_dout,  0);
        chk("arst_pkt_done", bus2.pkt_done,       0);
        chk("arst_drop_cnt", drop2,               0);
        chk("arst_err_cnt",  err2,                0);
        idle2();
        @(negedge clk);
        rst2_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_wr_en", bus2.ds_burst_wr_en, 0);
        d2 = {$urandom, $urandom};
        beat2(1, 8'hC0, 1, d2);
        chk("post_rst_fwd", bus2.ds_burst_wr_en, 4'b0001);
        chk("post_rst_done", bus2.pkt_done, 1);
        idle2();
        @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
